aes_key_expand: RTL and testbench

Iterative AES-128 key schedule. Takes a 128-bit cipher key and produces round keys 0..NUM_ROUNDS, one at a time, over a valid/ready handshake for the cipher datapath. Computes SubWord with four instances of the team's 1-cycle-latency sbox, which registers its input. The block drives the sbox inputs and consumes their outputs, so it sits directly upstream and downstream of the sbox.

---
 rtl/aes_key_expand.sv | 165 ++++++++++++++++
 tb/tb_aes_key_expand.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..NUM_ROUNDS over a valid/ready
// handshake, using four registered-input S-boxes for SubWord.

module aes_sbox (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o
);

    logic [7:0] din_q;

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (zero maps to zero), then the AES affine map.
    function automatic logic [7:0] subByte(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gfMul(sq, sq);
            inv = gfMul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) din_q <= 8'h00;
        else     din_q <= din_i;
    end

    assign dout_o = subByte(din_q);

endmodule

module aes_key_expand #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, OUT, SUB, MIX} state_e;

    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rotW3, subW, t;
    logic [31:0]  n0, n1, n2, n3;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // The S-boxes see RotWord(w3) every cycle; only the value captured at the end
    // of SUB matters, and key_q is static across OUT/SUB so that value is correct.
    assign rotW3 = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : gSbox
        aes_sbox uSbox (
            .clk    (clk),
            .rst    (rst),
            .din_i  (rotW3[31-8*i -: 8]),
            .dout_o (subW[31-8*i -: 8])
        );
    end

    assign t  = subW ^ {rcon_q, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = OUT;
            OUT:  if (rk_ready) state_d = (round_q == LastRound) ? IDLE : SUB;
            SUB:  state_d = MIX;
            MIX:  state_d = OUT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        rk_valid = (state_q == OUT);
    end

    always_comb begin
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = 4'd0;
                    rcon_d  = 8'h01;
                end
            end
            OUT: begin
                if (rk_ready && (round_q == LastRound)) done_d = 1'b1;
            end
            MIX: begin
                key_d   = {n0, n1, n2, n3};
                round_d = round_q + 4'd1;
                rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    assign rk       = key_q;
    assign rk_round = round_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 vectors, backpressure, ignored start,
// mid-expansion reset and a NUM_ROUNDS=2 build.

module tb_aes_key_expand;

    localparam logic [127:0] FipsKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] Key2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] Key2R1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] Key2R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, rkReady;
    logic [127:0] keyIn;
    logic         busy, rkValid, done;
    logic [3:0]   rkRound;
    logic [127:0] rk;

    logic         start2, rkReady2;
    logic [127:0] keyIn2;
    logic         busy2, rkValid2, done2;
    logic [3:0]   rkRound2;
    logic [127:0] rk2;

    logic [127:0] fipsRk [0:10];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aes_key_expand #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(keyIn), .rk_ready(rkReady),
        .busy(busy), .rk_valid(rkValid), .rk_round(rkRound), .rk(rk), .done(done)
    );

    aes_key_expand #(.NUM_ROUNDS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .key_in(keyIn2), .rk_ready(rkReady2),
        .busy(busy2), .rk_valid(rkValid2), .rk_round(rkRound2), .rk(rk2), .done(done2)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [127:0] k, input logic r);
        start   = s;
        keyIn   = k;
        rkReady = r;
    endtask

    // Full FIPS run with rk_ready high; optionally re-pulses start with another key.
    task automatic runFips(input string tag, input int injectCycle);
        applyStimulus(1'b1, FipsKey, 1'b1);
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            applyStimulus(c == injectCycle, Key2, 1'b1);
            checkOutput({tag, " valid"}, rkValid, ((c - 1) % 3 == 0) && (c <= 31));
            checkOutput({tag, " done"}, done, c == 32);
            checkOutput({tag, " busy"}, busy, c < 32);
            if (rkValid && ((c - 1) % 3 == 0)) begin
                checkOutput({tag, " round"}, rkRound, (c - 1) / 3);
                checkOutput({tag, " rk"}, rk, fipsRk[(c - 1) / 3]);
            end
        end
    endtask

    initial begin
        int hs;
        int doneCnt;
        bit finished;
        bit stalled;
        bit r;
        logic [127:0] heldRk;
        logic [3:0]   heldRound;

        fipsRk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fipsRk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fipsRk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fipsRk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fipsRk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fipsRk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fipsRk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fipsRk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fipsRk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fipsRk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fipsRk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b1);
        start2 = 1'b0; keyIn2 = '0; rkReady2 = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset valid", rkValid, 1'b0);
        checkOutput("reset round", rkRound, 4'd0);
        checkOutput("reset rk", rk, '0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset busy2", busy2, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        runFips("nominal", 0);

        // Start on the done-pulse cycle with the second FIPS key.
        applyStimulus(1'b1, Key2, 1'b1);
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            applyStimulus(1'b0, '0, 1'b1);
            if (c == 1) begin
                checkOutput("key2 r0 valid", rkValid, 1'b1);
                checkOutput("key2 r0 round", rkRound, 4'd0);
                checkOutput("key2 r0 rk", rk, Key2);
            end
            if (c == 4) checkOutput("key2 r1 rk", rk, Key2R1);
            if (c == 31) begin
                checkOutput("key2 r10 valid", rkValid, 1'b1);
                checkOutput("key2 r10 round", rkRound, 4'd10);
                checkOutput("key2 r10 rk", rk, Key2R10);
            end
            if (c == 32) begin
                checkOutput("key2 done", done, 1'b1);
                checkOutput("key2 busy", busy, 1'b0);
            end
        end

        // Random backpressure on the FIPS key.
        applyStimulus(1'b1, FipsKey, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0);
        hs = 0; doneCnt = 0; finished = 1'b0; stalled = 1'b0;
        heldRk = '0; heldRound = '0;
        for (int c = 0; c < 400 && !finished; c++) begin
            if (stalled) begin
                checkOutput("bp stable valid", rkValid, 1'b1);
                checkOutput("bp stable round", rkRound, heldRound);
                checkOutput("bp stable rk", rk, heldRk);
            end
            if (done) begin
                doneCnt++;
                checkOutput("bp done excl valid", rkValid, 1'b0);
                finished = 1'b1;
            end
            r = 1'($urandom_range(0, 1));
            rkReady = r;
            stalled = rkValid && !r;
            heldRk = rk;
            heldRound = rkRound;
            if (rkValid && r) begin
                if (hs <= 10) begin
                    checkOutput("bp round", rkRound, hs);
                    checkOutput("bp rk", rk, fipsRk[hs]);
                end else begin
                    checkOutput("bp extra handshake", hs, 10);
                end
                hs++;
            end
            if (!finished) @(negedge clk);
        end
        checkOutput("bp finished", finished, 1'b1);
        checkOutput("bp handshakes", hs, 11);
        rkReady = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("bp done count", doneCnt, 1);

        runFips("restart ignored", 13);
        @(negedge clk);

        // Reset during MIX of round 6 (cycle 18), then a fresh start.
        applyStimulus(1'b1, FipsKey, 1'b1);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkOutput("mix round", rkRound, 4'd5);
        checkOutput("mix valid", rkValid, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort busy", busy, 1'b0);
        checkOutput("abort valid", rkValid, 1'b0);
        checkOutput("abort round", rkRound, 4'd0);
        checkOutput("abort rk", rk, '0);
        checkOutput("abort done", done, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, FipsKey, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("fresh r0 round", rkRound, 4'd0);
        checkOutput("fresh r0 rk", rk, fipsRk[0]);
        repeat (3) @(negedge clk);
        checkOutput("fresh r1 valid", rkValid, 1'b1);
        checkOutput("fresh r1 rk", rk, fipsRk[1]);
        for (int c = 0; c < 40 && !done; c++) @(negedge clk);
        checkOutput("fresh done", done, 1'b1);

        // Reset wins over a simultaneous start.
        rst = 1'b1;
        applyStimulus(1'b1, FipsKey, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("rst+start busy", busy, 1'b0);
        checkOutput("rst+start valid", rkValid, 1'b0);
        @(negedge clk);
        checkOutput("rst+start idle", busy, 1'b0);

        // NUM_ROUNDS=2 build.
        start2 = 1'b1; keyIn2 = FipsKey;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (c == 1) checkOutput("nr2 r0 rk", rk2, fipsRk[0]);
            if (c == 4) checkOutput("nr2 r1 rk", rk2, fipsRk[1]);
            if (c == 7) begin
                checkOutput("nr2 r2 valid", rkValid2, 1'b1);
                checkOutput("nr2 r2 round", rkRound2, 4'd2);
                checkOutput("nr2 r2 rk", rk2, fipsRk[2]);
            end
            if (c == 8) begin
                checkOutput("nr2 done", done2, 1'b1);
                checkOutput("nr2 busy", busy2, 1'b0);
                checkOutput("nr2 valid", rkValid2, 1'b0);
            end
            if (c == 9) checkOutput("nr2 done pulse", done2, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
